// File: rtl/sdram_burst_datapath_if.sv
// Host-side handshake and data bus of the SDRAM burst datapath.
// master = burst requester / data source, slave = sdram_burst_datapath.
interface sdram_burst_datapath_if #(
  parameter int DQ_W = 16,
  parameter int BL_W = 4
);
  logic              wr_start;
  logic              rd_start;
  logic              abort;
  logic [BL_W-1:0]   burst_len;
  logic [DQ_W-1:0]   wr_data;
  logic [DQ_W/8-1:0] wr_be;
  logic              wr_data_req;
  logic [DQ_W-1:0]   rd_data;
  logic              rd_data_valid;
  logic              busy;
  logic              burst_done;

  modport master (
    output wr_start, rd_start, abort, burst_len, wr_data, wr_be,
    input  wr_data_req, rd_data, rd_data_valid, busy, burst_done
  );

  modport slave (
    input  wr_start, rd_start, abort, burst_len, wr_data, wr_be,
    output wr_data_req, rd_data, rd_data_valid, busy, burst_done
  );
endinterface

// File: rtl/sdram_burst_datapath.sv
// SDRAM burst datapath: write beats driven on sdram_dq one cycle after capture,
// read beats sampled after CAS latency. Define SDRAM_DQM_EN for a registered byte mask.
module sdram_burst_datapath #(
  parameter int DQ_W    = 16,
  parameter int BL_W    = 4,
  parameter int CAS_LAT = 3
) (
  input  logic                   clk,
  input  logic                   rst_n,
  sdram_burst_datapath_if.slave  bus,
  inout  wire  [DQ_W-1:0]        sdram_dq,
  output logic [DQ_W/8-1:0]      sdram_dqm
);
  localparam int BE_W = DQ_W / 8;
  localparam int WW   = 2;

  typedef enum logic [1:0] {IDLE, WRITE, RD_WAIT, READ} state_t;

  state_t            state_q, state_d;
  logic [BL_W-1:0]   cnt_q, cnt_d;
  logic [WW-1:0]     wait_q, wait_d;
  logic [DQ_W-1:0]   wdata_q, wdata_d;
  logic              oe_q, oe_d;
  logic [DQ_W-1:0]   rd_data_q, rd_data_d;
  logic              rd_valid_q, rd_valid_d;
  logic              done_q, done_d;
  logic [BL_W-1:0]   len_eff;

  assign len_eff = (bus.burst_len == '0) ? BL_W'(1) : bus.burst_len;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wait_d  = wait_q;
    case (state_q)
      IDLE: begin
        if (bus.wr_start) begin
          state_d = WRITE;
          cnt_d   = len_eff;
        end else if (bus.rd_start) begin
          state_d = RD_WAIT;
          cnt_d   = len_eff;
          wait_d  = WW'(CAS_LAT - 1);
        end
      end
      WRITE: begin
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == BL_W'(1)) state_d = IDLE;
      end
      RD_WAIT: begin
        wait_d = wait_q - 1'b1;
        if (wait_q == WW'(1)) state_d = READ;
      end
      READ: begin
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == BL_W'(1)) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (bus.abort && state_q != IDLE) begin
      state_d = IDLE;
      cnt_d   = '0;
      wait_d  = '0;
    end
  end

  // A beat captured in an abort cycle is still driven; only the done pulse is suppressed.
  always_comb begin
    wdata_d    = (state_q == WRITE) ? bus.wr_data : wdata_q;
    oe_d       = (state_q == WRITE);
    rd_valid_d = (state_q == READ) && !bus.abort;
    rd_data_d  = rd_valid_d ? sdram_dq : rd_data_q;
    done_d     = !bus.abort && (cnt_q == BL_W'(1)) &&
                 (state_q == WRITE || state_q == READ);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      wait_q     <= '0;
      wdata_q    <= '0;
      oe_q       <= 1'b0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      wait_q     <= wait_d;
      wdata_q    <= wdata_d;
      oe_q       <= oe_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      done_q     <= done_d;
    end
  end

  assign sdram_dq          = oe_q ? wdata_q : 'z;
  assign bus.wr_data_req   = (state_q == WRITE);
  assign bus.busy          = (state_q != IDLE);
  assign bus.rd_data       = rd_data_q;
  assign bus.rd_data_valid = rd_valid_q;
  assign bus.burst_done    = done_q;

`ifdef SDRAM_DQM_EN
  logic [BE_W-1:0] dqm_q, dqm_d;

  // Mask follows the driven beat; read states unmask the whole bus.
  always_comb begin
    if (state_q == WRITE)                          dqm_d = ~bus.wr_be;
    else if (state_d == RD_WAIT || state_d == READ) dqm_d = '0;
    else                                           dqm_d = '1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) dqm_q <= '1;
    else        dqm_q <= dqm_d;
  end

  assign sdram_dqm = dqm_q;
`else
  logic unused_be;
  assign unused_be = ^bus.wr_be;
  assign sdram_dqm = '0;
`endif
endmodule

// File: doc/sdram_burst_datapath.md
SDRAM_BURST_DATAPATH -- requirements
Module: sdram_burst_datapath

Interface
REQ-001 The module SHALL have parameter DQ_W, default 16, meaning SDRAM data bus width; legal values are multiples of 8.
REQ-002 The module SHALL have parameter BL_W, default 4, meaning the width of the burst length field.
REQ-003 The module SHALL have parameter CAS_LAT, default 3, meaning read CAS latency in clocks; legal values are 2 and 3 only.
REQ-004 The module SHALL have port clk, input, 1 bit: the single system clock; all logic is on its rising edge.
REQ-005 The module SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-006 The module SHALL have ports wr_start and rd_start, input, 1 bit each: one-cycle burst start requests.
REQ-007 The module SHALL have port abort, input, 1 bit: terminates the active burst.
REQ-008 The module SHALL have port burst_len, input, BL_W bits: number of beats, sampled with the start request.
REQ-009 The module SHALL have port wr_data, input, DQ_W bits, and port wr_be, input, DQ_W/8 bits: the write beat and its byte enables (1 = write).
REQ-010 The module SHALL have port wr_data_req, output, 1 bit: source must present a beat on wr_data/wr_be in the same cycle.
REQ-011 The module SHALL have port rd_data, output, DQ_W bits, and port rd_data_valid, output, 1 bit.
REQ-012 The module SHALL have port busy, output, 1 bit, and port burst_done, output, 1 bit (one-cycle pulse).
REQ-013 The module SHALL have port sdram_dq, inout, DQ_W bits, and port sdram_dqm, output, DQ_W/8 bits.

Function
REQ-014 The FSM SHALL have states IDLE, WRITE, RD_WAIT and READ; busy SHALL be 1 in any state other than IDLE.
REQ-015 In IDLE, wr_start SHALL go to WRITE and rd_start SHALL go to RD_WAIT; if both are high, write SHALL win and rd_start is dropped.
REQ-016 Start requests outside IDLE SHALL be ignored.
REQ-017 On a start, the beat counter SHALL load burst_len; a value of 0 SHALL be treated as 1.
REQ-018 wr_data_req SHALL equal (state==WRITE), so it is high for exactly N consecutive cycles.
REQ-019 wr_data SHALL be registered at each WRITE edge and driven on sdram_dq starting the following cycle (one-cycle lag).
REQ-020 The output-enable register SHALL be high for exactly those N cycles; otherwise sdram_dq SHALL be high impedance.
REQ-021 RD_WAIT SHALL last CAS_LAT-1 cycles; READ SHALL last N cycles and sample sdram_dq at each edge.
REQ-022 With rd_start high in cycle 0, rd_data_valid SHALL be high in cycles CAS_LAT+1 through CAS_LAT+N, and rd_data SHALL hold its last value otherwise.
REQ-023 burst_done SHALL pulse in the cycle carrying the last driven write beat or the last rd_data_valid.
REQ-024 After the final WRITE or READ cycle, the FSM SHALL return to IDLE; a new start may be accepted in the very next cycle (back-to-back).
REQ-025 abort in any non-IDLE state SHALL force IDLE at the next edge; a beat written in the abort cycle SHALL still be driven.
REQ-026 After abort, a read beat sampled in the abort cycle SHALL be discarded, no further valids SHALL occur, and burst_done SHALL NOT pulse.

Reset
REQ-027 While rst_n is low, the state SHALL be IDLE and the counters SHALL be 0.
REQ-028 While rst_n is low, output enable SHALL be 0 (sdram_dq high impedance), and wr_data_req, rd_data_valid, burst_done and busy SHALL be 0.
REQ-029 While rst_n is low, rd_data and the write data register SHALL be 0.
REQ-030 Reset asserted mid-burst SHALL release the bus immediately (asynchronously).

Configuration
REQ-031 With macro SDRAM_DQM_EN defined, sdram_dqm SHALL be registered alongside the data as ~wr_be during driven write beats, 0 during READ and RD_WAIT, and all-ones in IDLE and in reset.
REQ-032 Without SDRAM_DQM_EN, sdram_dqm SHALL be constant 0, wr_be SHALL be ignored, and no mask registers SHALL exist.

Verification
REQ-033 Write test: DQ_W=16, wr_start with burst_len=4, wr_data 0x1111..0x4444 -> wr_data_req high for 4 cycles; sdram_dq carries 0x1111..0x4444 one cycle later, then goes Z; burst_done pulses on 0x4444.
REQ-034 Read test: CAS_LAT=3, rd_start at cycle 0 with burst_len=2, model drives 0xA5A5 and 0x5A5A on sdram_dq in cycles 3-4 -> rd_data_valid high in cycles 4-5 with those values; burst_done pulses in cycle 5.
REQ-035 Edge-case test: wr_start and rd_start both high, burst_len=0 -> single write beat only; rd_start is lost; busy drops after 1 WRITE cycle.
REQ-036 Abort test: read burst_len=8 with abort in the 3rd READ cycle -> exactly 2 valids, no burst_done, IDLE next cycle.
REQ-037 Mask test (SDRAM_DQM_EN defined): wr_be=2'b01 -> sdram_dqm=2'b10 aligned with the beat; idle value 2'b11; without the macro, sdram_dqm is always 0.
REQ-038 Reset test: rst_n pulsed low during the 2nd write beat -> sdram_dq is Z immediately and all outputs are 0; after release, the FSM is in IDLE and accepts a new start.
